// File: rtl/half_adder_pkg.sv
// Shared constants and types for the half_adder block.
// Optional carry-event statistics are enabled with the HALF_ADDER_STATS_EN macro.
package half_adder_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 16;
  localparam int WIDTH_MAX = 64;

  typedef logic [WIDTH_DEF-1:0] lane_t;
  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with a one-cycle registered copy.
// Defining HALF_ADDER_STATS_EN adds a saturating carry-event counter (carry_cnt).
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX || CNT_W < 1) begin : g_bad_param
    $error("half_adder: WIDTH must be 1..64 and CNT_W at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  // Valid semantics: in_valid qualifies a/b on a rising edge; there is no
  // ready, so every qualified edge is accepted. out_valid is high for exactly
  // the cycles whose sum_q/carry_q came from an edge with in_valid=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        carry_q <= carry;
      end
    end
  end

`ifdef HALF_ADDER_STATS_EN
  // Counts qualified edges with any lane carrying; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (in_valid && (|carry) && (carry_cnt != {CNT_W{1'b1}})) begin
      carry_cnt <= carry_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder (WIDTH=1 and WIDTH=4/CNT_W=2 instances).
// Counter checks are compiled in when HALF_ADDER_STATS_EN is defined.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, in_valid1;
  logic       sum1, carry1, sum_q1, carry_q1, out_valid1;
  logic [3:0] a4, b4;
  logic       in_valid4;
  logic [3:0] sum4, carry4, sum_q4, carry_q4;
  logic       out_valid4;
`ifdef HALF_ADDER_STATS_EN
  logic [15:0] cnt1;
  logic [1:0]  cnt4;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid1),
    .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
    .out_valid(out_valid1)
`ifdef HALF_ADDER_STATS_EN
    , .carry_cnt(cnt1)
`endif
  );

  half_adder #(.WIDTH(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(in_valid4),
    .sum(sum4), .carry(carry4), .sum_q(sum_q4), .carry_q(carry_q4),
    .out_valid(out_valid4)
`ifdef HALF_ADDER_STATS_EN
    , .carry_cnt(cnt4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    in_valid4 = 1'b0; a4 = 4'b0; b4 = 4'b0;
    #1;
    check("rst_sum_q", 64'(sum_q1), 64'h0);
    check("rst_carry_q", 64'(carry_q1), 64'h0);
    check("rst_out_valid", 64'(out_valid1), 64'h0);
    check("rst_comb_00_sum", 64'(sum1), 64'h0);
    check("rst_comb_00_carry", 64'(carry1), 64'h0);
`ifdef HALF_ADDER_STATS_EN
    check("rst_cnt", 64'(cnt1), 64'h0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Combinational truth table, same timestep
    a1 = 1'b1; b1 = 1'b0; #1;
    check("comb_10_sum", 64'(sum1), 64'h1);
    check("comb_10_carry", 64'(carry1), 64'h0);
    a1 = 1'b1; b1 = 1'b1; #1;
    check("comb_11_sum", 64'(sum1), 64'h0);
    check("comb_11_carry", 64'(carry1), 64'h1);
    a1 = 1'b0; b1 = 1'b1; #1;
    check("comb_01_sum", 64'(sum1), 64'h1);
    check("comb_01_carry", 64'(carry1), 64'h0);
    a4 = 4'b1100; b4 = 4'b1010; #1;
    check("comb4_sum", 64'(sum4), 64'h6);
    check("comb4_carry", 64'(carry4), 64'h8);

    // Registered capture and hold
    @(negedge clk); in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    check("pre_cap_out_valid", 64'(out_valid1), 64'h0);
    edge_sample();
    check("cap_sum_q", 64'(sum_q1), 64'h0);
    check("cap_carry_q", 64'(carry_q1), 64'h1);
    check("cap_out_valid", 64'(out_valid1), 64'h1);
    @(negedge clk); in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    edge_sample();
    check("hold_sum_q", 64'(sum_q1), 64'h0);
    check("hold_carry_q", 64'(carry_q1), 64'h1);
    check("hold_out_valid", 64'(out_valid1), 64'h0);

    // Wide capture
    @(negedge clk); in_valid4 = 1'b1;
    edge_sample();
    check("cap4_sum_q", 64'(sum_q4), 64'h6);
    check("cap4_carry_q", 64'(carry_q4), 64'h8);
    check("cap4_out_valid", 64'(out_valid4), 64'h1);
    @(negedge clk); in_valid4 = 1'b0;

    // Reset between edges after a capture
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    edge_sample();
    check("pre_rst_carry_q", 64'(carry_q1), 64'h1);
    #2; rst_n = 1'b0; a1 = 1'b1; b1 = 1'b0; #1;
    check("mid_rst_sum_q", 64'(sum_q1), 64'h0);
    check("mid_rst_carry_q", 64'(carry_q1), 64'h0);
    check("mid_rst_out_valid", 64'(out_valid1), 64'h0);
    check("mid_rst_sum4_q", 64'(sum_q4), 64'h0);
    check("mid_rst_comb_sum", 64'(sum1), 64'h1);
`ifdef HALF_ADDER_STATS_EN
    check("mid_rst_cnt", 64'(cnt1), 64'h0);
    check("mid_rst_cnt4", 64'(cnt4), 64'h0);
`endif
    edge_sample();
    check("in_rst_out_valid", 64'(out_valid1), 64'h0);

    // First capture after release
    @(negedge clk); rst_n = 1'b1; a1 = 1'b1; b1 = 1'b1;
    edge_sample();
    check("rel_carry_q", 64'(carry_q1), 64'h1);
    check("rel_out_valid", 64'(out_valid1), 64'h1);

    // Saturating counter on the 2-bit instance
    @(negedge clk); in_valid1 = 1'b0; in_valid4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      edge_sample();
      check("cnt_seq_out_valid", 64'(out_valid4), 64'h1);
`ifdef HALF_ADDER_STATS_EN
      check($sformatf("cnt4_step%0d", k), 64'(cnt4), (k < 3) ? 64'(k + 1) : 64'h3);
`endif
    end
    @(negedge clk); in_valid4 = 1'b0;
    edge_sample();
    check("final_out_valid4", 64'(out_valid4), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
